rf_write_arbiter: RTL and testbench
===================================

// Module: rf_write_arbiter
// PURPOSE
//  Shares the register file's single write port between two writers:
//   - A: pipeline writeback stage; never stalled, always wins.
//   - B: long-latency unit (mul/div, or a load miss), using valid/ready.
//  Keeps a busy-bit scoreboard of registers with an outstanding B result.
//  Decode uses the scoreboard to hold off RAW/WAW hazards.
//  A starvation counter raises stall_req so B cannot wait forever.
//  Sits between the WB stage / long-latency unit and the register file's write inputs.
// PARAMETERS
//  XLEN      32  data width of write data
//  MAX_WAIT  4   consecutive blocked B cycles before stall_req rises (1..255)
// PORTS
//  clk        in   1     clock; all state updates on posedge
//  rst        in   1     reset, asynchronous, active-high
//  a_we       in   1     A write enable
//  a_wr       in   5     A destination register
//  a_wd       in   XLEN  A write data
//  b_valid    in   1     B has a result pending
//  b_wr       in   5     B destination register
//  b_wd       in   XLEN  B write data
//  b_ready    out  1     B result committed this cycle when b_valid && b_ready
//  iss_valid  in   1     decode issuing an op to the B unit
//  iss_rd     in   5     destination of the issuing op
//  iss_ready  out  1     issue permitted (destination not busy)
//  rs1, rs2   in   5     decode source registers
//  rs1_busy   out  1     rs1 has an outstanding B write
//  rs2_busy   out  1     rs2 has an outstanding B write
//  stall_req  out  1     request to the pipeline to bubble A so B can write
//  rf_we      out  1     to register file RegWrite
//  rf_wr      out  5     to register file wr
//  rf_wd      out  XLEN  to register file wd
//  waw_err    out  1     sticky: A wrote a register marked busy
// BEHAVIOUR
//  Active-A condition: a_act = a_we && (a_wr != 0).
//  Write mux (combinational, zero latency):
//   - a_act      -> rf_we=1, rf_wr=a_wr, rf_wd=a_wd.
//   - else       -> rf_we = b_valid && (b_wr != 0); rf_wr=b_wr; rf_wd=b_wd.
//  b_ready = !a_act && !rst. It does not depend on b_valid.
//  B commit = b_valid && b_ready. B must hold wr/wd stable until commit.
//  Scoreboard: busy[31:0] registers; busy[0] is always 0.
//   - iss_ready = !busy[iss_rd] || (iss_rd == 0); uses registered busy only.
//   - Issue fires (iss_valid && iss_ready && iss_rd != 0) -> set busy[iss_rd].
//   - B commit with b_wr != 0 -> clear busy[b_wr].
//   - Same-cycle clear of X and issue to X cannot happen: iss_ready was low.
//     Clear and set on different registers both take effect.
//  rsN_busy = busy[rsN] (registered state). A commit this cycle does not bypass.
//  waw_err: set on an edge where a_act && busy[a_wr]. A's write still happens;
//   busy is unchanged. Cleared only by rst.
//  Starvation: wait_cnt (8b) increments, saturating, each cycle b_valid && !b_ready.
//   It clears to 0 on B commit or when b_valid=0.
//  stall_req (registered):
//   - set on an edge where the blocked condition holds and wait_cnt == MAX_WAIT-1;
//   - cleared on the edge after B commit, or when b_valid drops.
//   - The pipeline drops a_we while stall_req=1. If A writes anyway, A still wins.
//  Reset: busy=0, wait_cnt=0, stall_req=0, waw_err=0; b_ready=0 while rst.
//   Reset mid-operation drops all pending scoreboard entries; the B unit is reset too.
//   The combinational outputs rf_we/rf_wr/rf_wd follow the write mux.
// TESTING
//  A only: a_we=1,a_wr=5,a_wd=0xAA -> rf_we=1,rf_wr=5,rf_wd=0xAA same cycle; b_ready=0.
//  Conflict: A wr=3 and B valid wr=7 same cycle -> rf_wr=3, b_ready=0;
//   next cycle a_we=0 -> rf_wr=7, B commits.
//  Scoreboard: issue rd=9 -> busy[9]=1, rs1=9 gives rs1_busy=1, re-issue rd=9 gives iss_ready=0;
//   B commit wr=9 -> busy clear next edge.
//  Starvation (MAX_WAIT=4): A writes every cycle, B valid from cycle 0
//   -> stall_req=1 from cycle 4; a_we=0 at cycle 5 -> B commits, stall_req=0 at cycle 6.
//  x0 handling: issue rd=0 -> no busy set; A a_wr=0 with B valid -> B granted;
//   B b_wr=0 -> rf_we=0 but commit occurs.
//  WAW + reset: busy[4]=1, A writes 4 -> waw_err=1, rf_wr=4;
//   assert rst mid-wait -> busy, stall_req, waw_err all 0 immediately.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: the writeback stage (A) always wins, the long-latency
// unit (B) takes idle cycles. Also tracks registers with a B result still outstanding.
module rf_write_arbiter #(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            a_we,
    input  logic [4:0]      a_wr,
    input  logic [XLEN-1:0] a_wd,
    input  logic            b_valid,
    input  logic [4:0]      b_wr,
    input  logic [XLEN-1:0] b_wd,
    output logic            b_ready,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    output logic            iss_ready,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic            rs1_busy,
    output logic            rs2_busy,
    output logic            stall_req,
    output logic            rf_we,
    output logic [4:0]      rf_wr,
    output logic [XLEN-1:0] rf_wd,
    output logic            waw_err
);

    localparam logic [7:0] WAIT_TC = 8'(MAX_WAIT - 1);

    logic [31:0] busy;
    logic [31:0] busy_set;
    logic [31:0] busy_clr;
    logic [7:0]  wait_cnt;
    logic        a_act;
    logic        b_commit;
    logic        b_blocked;
    logic        iss_fire;

    assign a_act     = a_we && (a_wr != 5'd0);
    assign b_ready   = !a_act && !rst;
    assign b_commit  = b_valid && b_ready;
    assign b_blocked = b_valid && !b_ready;

    always_comb begin
        if (a_act) begin
            rf_we = 1'b1;
            rf_wr = a_wr;
            rf_wd = a_wd;
        end else begin
            rf_we = b_valid && (b_wr != 5'd0);
            rf_wr = b_wr;
            rf_wd = b_wd;
        end
    end

    // Issue and hazard lookups see only the registered busy bits; no bypass from this cycle's commit.
    assign iss_ready = !busy[iss_rd] || (iss_rd == 5'd0);
    assign iss_fire  = iss_valid && iss_ready && (iss_rd != 5'd0);
    assign rs1_busy  = busy[rs1];
    assign rs2_busy  = busy[rs2];

    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (iss_fire)
            busy_set[iss_rd] = 1'b1;
        if (b_commit && (b_wr != 5'd0))
            busy_clr[b_wr] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            busy <= '0;
        else
            busy <= ((busy & ~busy_clr) | busy_set) & 32'hFFFF_FFFE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            waw_err <= 1'b0;
        else if (a_act && busy[a_wr])
            waw_err <= 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wait_cnt <= '0;
        else if (b_blocked)
            wait_cnt <= (wait_cnt == 8'hFF) ? wait_cnt : wait_cnt + 8'd1;
        else
            wait_cnt <= '0;
    end

    // Once raised, stall_req holds until B gets its slot or withdraws.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stall_req <= 1'b0;
        else if (b_commit || !b_valid)
            stall_req <= 1'b0;
        else if (b_blocked && (wait_cnt == WAIT_TC))
            stall_req <= 1'b1;
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: mux vector table, hand sequences for the multi-cycle
// corners, then random traffic against a scoreboard-level reference model.
module tb_rf_write_arbiter;

    localparam int XLEN     = 32;
    localparam int MAX_WAIT = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            a_we, b_valid, iss_valid;
    logic [4:0]      a_wr, b_wr, iss_rd, rs1, rs2;
    logic [XLEN-1:0] a_wd, b_wd;
    logic            b_ready, iss_ready, rs1_busy, rs2_busy, stall_req, rf_we, waw_err;
    logic [4:0]      rf_wr;
    logic [XLEN-1:0] rf_wd;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rf_write_arbiter #(.XLEN(XLEN), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .a_we(a_we), .a_wr(a_wr), .a_wd(a_wd),
        .b_valid(b_valid), .b_wr(b_wr), .b_wd(b_wd), .b_ready(b_ready),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
        .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .stall_req(stall_req),
        .rf_we(rf_we), .rf_wr(rf_wr), .rf_wd(rf_wd),
        .waw_err(waw_err)
    );

    typedef struct {
        logic        a_we;
        logic [4:0]  a_wr;
        logic [31:0] a_wd;
        logic        b_valid;
        logic [4:0]  b_wr;
        logic [31:0] b_wd;
        logic        e_we;
        logic [4:0]  e_wr;
        logic [31:0] e_wd;
        logic        e_ready;
    } vec_t;

    vec_t tbl[8];

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chkv(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_mux(input string tag, input logic e_we, input logic [4:0] e_wr,
                           input logic [31:0] e_wd, input logic e_ready);
        chk1({tag, " rf_we"}, rf_we, e_we);
        chkv({tag, " rf_wr"}, {27'd0, rf_wr}, {27'd0, e_wr});
        chkv({tag, " rf_wd"}, rf_wd, e_wd);
        chk1({tag, " b_ready"}, b_ready, e_ready);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        a_we = 0; a_wr = 0; a_wd = 0;
        b_valid = 0; b_wr = 0; b_wd = 0;
        iss_valid = 0; iss_rd = 0; rs1 = 0; rs2 = 0;
    endtask

    // Reference model state: busy set, length of the current blocked run, sticky WAW flag.
    bit [31:0] m_busy;
    int        m_run;
    bit        m_waw;

    initial begin
        tbl[0] = '{1'b1, 5'd5,  32'hAA,        1'b0, 5'd0, 32'h0,  1'b1, 5'd5,  32'hAA,        1'b0};
        tbl[1] = '{1'b1, 5'd3,  32'h11,        1'b1, 5'd7, 32'h77, 1'b1, 5'd3,  32'h11,        1'b0};
        tbl[2] = '{1'b0, 5'd3,  32'h11,        1'b1, 5'd7, 32'h77, 1'b1, 5'd7,  32'h77,        1'b1};
        tbl[3] = '{1'b1, 5'd0,  32'h55,        1'b1, 5'd6, 32'h66, 1'b1, 5'd6,  32'h66,        1'b1};
        tbl[4] = '{1'b0, 5'd0,  32'h0,         1'b1, 5'd0, 32'h99, 1'b0, 5'd0,  32'h99,        1'b1};
        tbl[5] = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0, 32'h0,  1'b0, 5'd0,  32'h0,         1'b1};
        tbl[6] = '{1'b0, 5'd8,  32'h1,         1'b0, 5'd2, 32'h22, 1'b0, 5'd2,  32'h22,        1'b1};
        tbl[7] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1, 5'd1, 32'h1,  1'b1, 5'd31, 32'hFFFF_FFFF, 1'b0};

        clr_in();
        rs1 = 5; iss_rd = 5;
        #2;
        chk1("rst b_ready", b_ready, 1'b0);
        chk1("rst rs1_busy", rs1_busy, 1'b0);
        chk1("rst stall_req", stall_req, 1'b0);
        chk1("rst waw_err", waw_err, 1'b0);
        chk1("rst iss_ready", iss_ready, 1'b1);
        chk1("rst rf_we", rf_we, 1'b0);
        @(posedge clk);
        #1 rst = 0;

        for (int i = 0; i < 8; i++) begin
            a_we = tbl[i].a_we; a_wr = tbl[i].a_wr; a_wd = tbl[i].a_wd;
            b_valid = tbl[i].b_valid; b_wr = tbl[i].b_wr; b_wd = tbl[i].b_wd;
            #4;
            chk_mux($sformatf("vec%0d", i), tbl[i].e_we, tbl[i].e_wr, tbl[i].e_wd, tbl[i].e_ready);
            tick();
        end
        clr_in();
        tick();

        // Scoreboard: set on issue, block re-issue, clear on B commit, set+clear together.
        iss_valid = 1; iss_rd = 9; rs1 = 9;
        #4;
        chk1("sb issue9 ready", iss_ready, 1'b1);
        chk1("sb rs1 before", rs1_busy, 1'b0);
        tick();
        rs2 = 9;
        #4;
        chk1("sb reissue9 ready", iss_ready, 1'b0);
        chk1("sb rs1 busy9", rs1_busy, 1'b1);
        chk1("sb rs2 busy9", rs2_busy, 1'b1);
        tick();
        iss_rd = 10; b_valid = 1; b_wr = 9; b_wd = 32'h5;
        #4;
        chk1("sb issue10 ready", iss_ready, 1'b1);
        chk_mux("sb commit9", 1'b1, 5'd9, 32'h5, 1'b1);
        chk1("sb busy9 held", rs1_busy, 1'b1);
        tick();
        iss_valid = 0; b_valid = 0; rs1 = 9; rs2 = 10;
        #4;
        chk1("sb busy9 cleared", rs1_busy, 1'b0);
        chk1("sb busy10 set", rs2_busy, 1'b1);
        b_valid = 1; b_wr = 10;
        tick();
        b_valid = 0;
        #4;
        chk1("sb busy10 cleared", rs2_busy, 1'b0);
        tick();

        // x0: issue to r0 never marks busy
        iss_valid = 1; iss_rd = 0; rs1 = 0;
        #4;
        chk1("x0 iss_ready", iss_ready, 1'b1);
        tick();
        #4;
        chk1("x0 iss_ready after", iss_ready, 1'b1);
        chk1("x0 rs1_busy", rs1_busy, 1'b0);
        clr_in();
        tick();

        // Starvation: A writes cycles 0..4, B valid from cycle 0, A yields at cycle 5.
        for (int c = 0; c <= 6; c++) begin
            a_we = (c < 5); a_wr = 3; a_wd = 32'(c);
            b_valid = (c <= 5); b_wr = 7; b_wd = 32'h77;
            #4;
            chk1($sformatf("starve c%0d stall_req", c), stall_req, (c == 4 || c == 5));
            chk1($sformatf("starve c%0d b_ready", c), b_ready, (c >= 5));
            tick();
        end
        clr_in();
        tick();

        // WAW on a busy register, then reset in the middle of a starvation wait.
        iss_valid = 1; iss_rd = 4;
        tick();
        iss_valid = 0; a_we = 1; a_wr = 4; a_wd = 32'h44; rs1 = 4;
        #4;
        chk_mux("waw a4", 1'b1, 5'd4, 32'h44, 1'b0);
        chk1("waw pre err", waw_err, 1'b0);
        tick();
        a_wr = 3; b_valid = 1; b_wr = 4; b_wd = 32'h4;
        #4;
        chk1("waw err set", waw_err, 1'b1);
        chk1("waw busy4 kept", rs1_busy, 1'b1);
        for (int c = 0; c < 4; c++) tick();
        #2;
        chk1("waw stall up", stall_req, 1'b1);
        rst = 1;
        #1;
        chk1("midrst rs1_busy", rs1_busy, 1'b0);
        chk1("midrst stall_req", stall_req, 1'b0);
        chk1("midrst waw_err", waw_err, 1'b0);
        chk1("midrst b_ready", b_ready, 1'b0);
        clr_in();
        tick();
        rst = 0;

        // Random traffic against the reference model; B holds its request until committed.
        m_busy = '0; m_run = 0; m_waw = 0;
        for (int n = 0; n < 500; n++) begin
            logic        act, exp_we, commit, fire;
            logic [4:0]  exp_wr;
            logic [31:0] exp_wd;
            a_we = ($urandom_range(9) < 6); a_wr = 5'($urandom_range(7)); a_wd = $urandom;
            if (!b_valid) begin
                b_valid = $urandom_range(1);
                b_wr = 5'($urandom_range(7));
                b_wd = $urandom;
            end
            iss_valid = $urandom_range(1); iss_rd = 5'($urandom_range(7));
            rs1 = 5'($urandom_range(7)); rs2 = 5'($urandom_range(7));
            #4;
            act    = a_we && (a_wr != 0);
            exp_we = act ? 1'b1 : (b_valid && (b_wr != 0));
            exp_wr = act ? a_wr : b_wr;
            exp_wd = act ? a_wd : b_wd;
            chk_mux($sformatf("rnd%0d", n), exp_we, exp_wr, exp_wd, !act);
            chk1($sformatf("rnd%0d iss_ready", n), iss_ready, !m_busy[iss_rd]);
            chk1($sformatf("rnd%0d rs1_busy", n), rs1_busy, m_busy[rs1]);
            chk1($sformatf("rnd%0d rs2_busy", n), rs2_busy, m_busy[rs2]);
            chk1($sformatf("rnd%0d stall_req", n), stall_req, (m_run >= MAX_WAIT));
            chk1($sformatf("rnd%0d waw_err", n), waw_err, m_waw);
            commit = b_valid && !act;
            fire   = iss_valid && (iss_rd != 0) && !m_busy[iss_rd];
            if (act && m_busy[a_wr]) m_waw = 1;
            if (commit && b_wr != 0) m_busy[b_wr] = 0;
            if (fire) m_busy[iss_rd] = 1;
            m_run = (b_valid && act) ? m_run + 1 : 0;
            tick();
            if (commit) b_valid = 0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
